lfsr_seq_monitor: RTL and testbench
===================================

# lfsr_seq_monitor

Checker stage that sits directly downstream of the 3-bit shift-register sequence generator and consumes its {X2,X1,X0} outputs. It locks onto the generator's 8-state cycle at the seed value, then predicts and compares every following state. It reports lock status, sequence position, per-period wrap pulses and mismatch errors, and drops lock after a configurable number of consecutive mismatches. It is used on the lab board to prove that the generator runs its full period and to count faults.

## Interface
- ERR_LIMIT, default 3: number of consecutive mismatches in TRACK that force a return to HUNT. Legal range 1..7.
- SEED, default 3'b100: generator value loaded at its reset. Marks sequence position 0.
- CLK  in  1  system clock. Same clock as the generator. All logic is rising-edge.
- RESET_L  in  1  reset, synchronous, active-low. Sampled on the CLK rising edge.
- EN  in  1  sample enable. When high, X is evaluated on this edge.
- X  in  3  generator state, {X2,X1,X0}.
- LOCK  out  1  high while in TRACK.
- STEP  out  3  position of the last accepted X within the sequence, 0..7.
- WRAP  out  1  one-cycle pulse when SEED is accepted in TRACK.
- ERR  out  1  one-cycle pulse on a mismatch in TRACK.
- ERR_CNT  out  8  total mismatches since reset. Saturates at 255.

## Operation
- Next-state function, identical to the generator: nxt(X) = {~(X2|X1) ^ X1 ^ X0, X2, X1}.
- Sequence from SEED=100: 100, 010, 101, 110, 111, 011, 001, 000, then back to 100. The period is 8 and every 3-bit value appears once.
- Position table, fixed for the default seed: 100→0, 010→1, 101→2, 110→3, 111→4, 011→5, 001→6, 000→7.
- Internal registers:
  - state: HUNT or TRACK.
  - exp[2:0]: expected next X.
  - miss[2:0]: consecutive-mismatch count.
- HUNT behaviour:
  - LOCK=0, and no ERR or WRAP pulses are generated.
  - On EN=1 with X==SEED: go to TRACK, set exp=nxt(SEED), miss=0, STEP=0.
  - On EN=1 with X!=SEED: stay in HUNT.
- TRACK behaviour, on each EN=1 cycle:
  - Match (X==exp):
    - miss=0, STEP=pos(X), exp=nxt(X).
    - WRAP=1 if X==SEED.
  - Mismatch (X!=exp):
    - ERR=1.
    - ERR_CNT increments, saturating at 255.
    - miss increments, exp=nxt(X) so the monitor re-aligns on the observed value, and STEP=pos(X).
    - If the incremented miss equals ERR_LIMIT: go to HUNT, LOCK=0 from the next cycle, miss=0.
- EN=0 in any state:
  - All registers hold.
  - ERR and WRAP are 0.
  - No comparison is made.
- ERR_CNT is not cleared on a return to HUNT. Only reset clears it.
- A mismatch whose X equals SEED gives ERR=1 and WRAP=0. WRAP is issued only on matched samples.

## Timing
- Every output is registered. The response to a sample accepted on edge n is visible after edge n, i.e. in cycle n+1.
- Reset, with RESET_L=0 on an edge:
  - state=HUNT, LOCK=0, STEP=0, WRAP=0, ERR=0, ERR_CNT=0, miss=0, exp=SEED.
  - Reset has priority over EN.
  - Asserting reset mid-TRACK aborts on that edge. No ERR or WRAP pulse is emitted for that edge's sample.
- Lock latency: LOCK rises one cycle after the edge on which SEED is sampled in HUNT.
- Unlock latency: LOCK falls one cycle after the edge that carries the ERR_LIMIT-th consecutive mismatch. ERR is high in the same cycle LOCK falls.
- While locked and fault-free, WRAP pulses once every 8 EN samples.
- ERR_CNT at 255 stays at 255 on further mismatches. ERR still pulses.
- Back-to-back EN is legal every cycle, with no throughput limit.

## Test plan
- Reset, then generator feed with EN=1 every cycle, starting at 100:
  - LOCK=1 from cycle 2.
  - STEP runs 0,1,…,7,0.
  - WRAP pulses on every 8th sample.
  - ERR stays 0 and ERR_CNT=0 after 64 samples.
- Locked, then one corrupted sample (expected 101, drive 000), then the correct sequence from nxt(000)=100:
  - One ERR pulse, ERR_CNT=1, LOCK stays 1.
  - Next sample 100 gives WRAP=1 and STEP=0.
- Locked, then 3 consecutive mismatches with default ERR_LIMIT (X driven constant at 111 over 4 samples):
  - The first 111 matches.
  - 3 ERR pulses follow, ERR_CNT=3, and LOCK=0 after the third.
  - Subsequent 111 samples produce no ERR.
- HUNT with X=010,101 and EN=1: LOCK stays 0 until 100 is presented, then LOCK=1 and STEP=0.
- EN toggling 1,0,0,1 while locked:
  - Outputs hold across EN=0.
  - The sequence continues with no ERR.
  - STEP advances by one only per EN=1 sample.
- Reset mid-TRACK:
  - Drive RESET_L=0 for 1 cycle while the sample on that edge mismatches.
  - Required: no ERR pulse, LOCK=0, ERR_CNT=0.
- ERR_CNT saturation: drive 300 mismatching samples with lock forced by repeated SEED resync; ERR_CNT=255 and ERR still pulses.

Source files
------------

// File: rtl/lfsr_seq_monitor.sv
// Sequence checker for the 3-bit shift-register generator: locks on SEED,
// predicts each following state and reports position, wraps and mismatches.
module lfsr_seq_monitor #(
    parameter int         ERR_LIMIT = 3,
    parameter logic [2:0] SEED      = 3'b100
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       EN,
    input  logic [2:0] X,
    output logic       LOCK,
    output logic [2:0] STEP,
    output logic       WRAP,
    output logic       ERR,
    output logic [7:0] ERR_CNT
);

    typedef enum logic {HUNT, TRACK} state_t;

    localparam logic [2:0] LIMIT = 3'(ERR_LIMIT);

    state_t     state;
    logic [2:0] exp_x;
    logic [2:0] miss;
    logic [2:0] miss_inc;

    function automatic logic [2:0] nxt(input logic [2:0] v);
        return {~(v[2] | v[1]) ^ v[1] ^ v[0], v[2], v[1]};
    endfunction

    // Position = number of generator steps from SEED; the period is 8, so
    // every value is reached exactly once in the walk.
    function automatic logic [2:0] pos(input logic [2:0] v);
        logic [2:0] s;
        logic [2:0] p;
        s = SEED;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s == v) p = 3'(i);
            s = nxt(s);
        end
        return p;
    endfunction

    assign miss_inc = miss + 3'd1;

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state   <= HUNT;
            exp_x   <= SEED;
            miss    <= 3'd0;
            LOCK    <= 1'b0;
            STEP    <= 3'd0;
            WRAP    <= 1'b0;
            ERR     <= 1'b0;
            ERR_CNT <= 8'd0;
        end else begin
            WRAP <= 1'b0;
            ERR  <= 1'b0;
            if (EN) begin
                case (state)
                    HUNT: begin
                        if (X == SEED) begin
                            state <= TRACK;
                            LOCK  <= 1'b1;
                            exp_x <= nxt(SEED);
                            miss  <= 3'd0;
                            STEP  <= 3'd0;
                        end
                    end
                    TRACK: begin
                        STEP  <= pos(X);
                        exp_x <= nxt(X);
                        if (X == exp_x) begin
                            miss <= 3'd0;
                            WRAP <= (X == SEED);
                        end else begin
                            ERR <= 1'b1;
                            if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
                            // Too many misses in a row: drop lock and rehunt
                            if (miss_inc == LIMIT) begin
                                state <= HUNT;
                                LOCK  <= 1'b0;
                                miss  <= 3'd0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Directed plus randomized bench for lfsr_seq_monitor, checked against a
// table-driven model of the generator's 8-state cycle.
module tb_lfsr_seq_monitor;

    localparam int         ERR_LIMIT = 3;
    localparam logic [2:0] SEED      = 3'b100;

    logic       CLK = 1'b0;
    logic       RESET_L;
    logic       EN;
    logic [2:0] X;
    logic       LOCK;
    logic [2:0] STEP;
    logic       WRAP;
    logic       ERR;
    logic [7:0] ERR_CNT;

    lfsr_seq_monitor #(.ERR_LIMIT(ERR_LIMIT), .SEED(SEED)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .EN(EN), .X(X),
        .LOCK(LOCK), .STEP(STEP), .WRAP(WRAP), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference: the published cycle as a lookup table.
    logic [2:0] seq [8];
    logic       m_lock;
    logic [2:0] m_exp;
    int         m_miss;
    logic [2:0] m_step;
    logic       m_wrap;
    logic       m_err;
    int         m_cnt;

    function automatic int posof(input logic [2:0] v);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (seq[i] == v) p = i;
        return p;
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] v);
        return seq[(posof(v) + 1) % 8];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic rst_n, input logic en, input logic [2:0] x);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_lock = 1'b0; m_exp = SEED; m_miss = 0; m_step = 3'd0; m_cnt = 0;
        end else if (en) begin
            if (!m_lock) begin
                if (x == SEED) begin
                    m_lock = 1'b1; m_exp = succ(x); m_miss = 0; m_step = 3'd0;
                end
            end else if (x == m_exp) begin
                m_miss = 0; m_step = 3'(posof(x)); m_exp = succ(x);
                m_wrap = (x == SEED);
            end else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
                m_miss++;
                m_exp  = succ(x);
                m_step = 3'(posof(x));
                if (m_miss == ERR_LIMIT) begin
                    m_lock = 1'b0; m_miss = 0;
                end
            end
        end
    endtask

    task automatic step(input logic rst_n, input logic en, input logic [2:0] x);
        RESET_L = rst_n; EN = en; X = x;
        @(posedge CLK);
        model(rst_n, en, x);
        #1;
        check("lock",    {7'd0, LOCK}, {7'd0, m_lock});
        check("step",    {5'd0, STEP}, {5'd0, m_step});
        check("wrap",    {7'd0, WRAP}, {7'd0, m_wrap});
        check("err",     {7'd0, ERR},  {7'd0, m_err});
        check("err_cnt", ERR_CNT,      8'(m_cnt));
    endtask

    initial begin
        int wraps;
        int errs;
        seq = '{3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
        m_lock = 1'b0; m_exp = SEED; m_miss = 0; m_step = 3'd0;
        m_wrap = 1'b0; m_err = 1'b0; m_cnt = 0;
        RESET_L = 1'b0; EN = 1'b0; X = 3'b000;

        // Reset state
        step(1'b0, 1'b1, 3'b100);
        step(1'b0, 1'b0, 3'b000);
        check("rst_lock", {7'd0, LOCK}, 8'd0);
        check("rst_cnt",  ERR_CNT,      8'd0);

        // Clean run: 64 samples from SEED
        wraps = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, seq[i % 8]);
            if (i == 0) check("lock_rise", {7'd0, LOCK}, 8'd1);
            if (i == 7) check("step7", {5'd0, STEP}, 8'd7);
            if (WRAP) wraps++;
        end
        check("wraps64", 8'(wraps), 8'd7);
        check("clean_cnt", ERR_CNT, 8'd0);

        // Single corrupted sample, then resume from nxt(000)=100
        step(1'b1, 1'b1, 3'b100);
        check("wrap_at_seed", {7'd0, WRAP}, 8'd1);
        step(1'b1, 1'b1, 3'b010);
        step(1'b1, 1'b1, 3'b000);
        check("corrupt_err",  {7'd0, ERR},  8'd1);
        check("corrupt_cnt",  ERR_CNT,      8'd1);
        check("corrupt_lock", {7'd0, LOCK}, 8'd1);
        step(1'b1, 1'b1, 3'b100);
        check("resync_wrap", {7'd0, WRAP}, 8'd1);
        check("resync_step", {5'd0, STEP}, 8'd0);

        // Constant 111: one match then ERR_LIMIT misses drop lock
        step(1'b1, 1'b1, 3'b010);
        step(1'b1, 1'b1, 3'b101);
        step(1'b1, 1'b1, 3'b110);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 3'b111);
            if (ERR) errs++;
        end
        check("stuck_errs", 8'(errs), 8'd3);
        check("stuck_cnt",  ERR_CNT,  8'd4);
        check("stuck_lock", {7'd0, LOCK}, 8'd0);
        step(1'b1, 1'b1, 3'b111);
        step(1'b1, 1'b1, 3'b111);
        check("hunt_no_err", {7'd0, ERR}, 8'd0);

        // HUNT ignores non-seed values
        step(1'b1, 1'b1, 3'b010);
        step(1'b1, 1'b1, 3'b101);
        check("hunt_lock0", {7'd0, LOCK}, 8'd0);
        step(1'b1, 1'b1, 3'b100);
        check("relock", {7'd0, LOCK}, 8'd1);
        check("relock_step", {5'd0, STEP}, 8'd0);

        // EN gaps while locked
        step(1'b1, 1'b1, 3'b010);
        step(1'b1, 1'b0, 3'b111);
        step(1'b1, 1'b0, 3'b000);
        check("hold_step", {5'd0, STEP}, 8'd1);
        step(1'b1, 1'b1, 3'b101);
        check("gap_step", {5'd0, STEP}, 8'd2);
        check("gap_err",  {7'd0, ERR},  8'd0);

        // Reset mid-TRACK with a mismatching sample on that edge
        step(1'b0, 1'b1, 3'b000);
        check("rst_mid_err",  {7'd0, ERR},  8'd0);
        check("rst_mid_lock", {7'd0, LOCK}, 8'd0);
        check("rst_mid_cnt",  ERR_CNT,      8'd0);

        // Randomized traffic, mostly on-sequence
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic       e;
            logic [2:0] x;
            r = ($urandom_range(0, 49) != 0);
            e = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 9) < 7) ? (m_lock ? m_exp : SEED) : 3'($urandom_range(0, 7));
            step(r, e, x);
        end

        // Saturation: 100 lock/three-miss rounds = 300 mismatches
        step(1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 3'b100);
            for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 3'b111);
        end
        check("sat_cnt", ERR_CNT, 8'd255);
        check("sat_err", {7'd0, ERR}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
